arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter BUS_BITS, default 64, width of each data channel.
REQ-002 Parameter NUM_INPUTS, default 4, channel count; legal range 2..16.
REQ-003 Parameter ARB_MODE, default 1; 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-004 Derived SEL_BITS SHALL be clog2(NUM_INPUTS), minimum 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  NUM_INPUTS*BUS_BITS  channel i occupies bits [i*BUS_BITS +: BUS_BITS].
REQ-008 in_valid  input  NUM_INPUTS  per-channel request.
REQ-009 in_ready  output  NUM_INPUTS  per-channel accept; one-hot or zero.
REQ-010 out  output  BUS_BITS  registered selected data.
REQ-011 out_valid  output  1  out holds an unconsumed word.
REQ-012 out_ready  input  1  downstream accepts out this cycle.
REQ-013 out_sel  output  SEL_BITS  index of channel that produced out.

Function
REQ-014 Output stage SHALL be a single-entry register; "can_load" = !out_valid || out_ready.
REQ-015 A channel i is granted in a cycle only when can_load and in_valid[i] and i wins arbitration; in_ready SHALL be combinational from in_valid, out_valid, out_ready and the priority pointer.
REQ-016 At most one in_ready bit SHALL be high; when can_load is 0 or no in_valid is set, in_ready SHALL be all zero.
REQ-017 Transfer on a channel occurs when in_valid[i] && in_ready[i]; on that edge out <= channel i data, out_sel <= i, out_valid <= 1.
REQ-018 When out_valid && out_ready and no grant, out_valid SHALL clear on the edge; out and out_sel hold their last values.
REQ-019 When out_valid && !out_ready, out, out_sel and out_valid SHALL hold unchanged (no overwrite).
REQ-020 Simultaneous pop and grant SHALL load the new word with out_valid staying 1; sustained throughput one word per cycle.
REQ-021 Latency from accepted input to out_valid SHALL be exactly one cycle.
REQ-022 ARB_MODE 0: winner is lowest index i with in_valid[i]; pointer unused and held at 0.
REQ-023 ARB_MODE 1: pointer ptr (SEL_BITS) marks highest priority; search order ptr, ptr+1, ... wrapping modulo NUM_INPUTS.
REQ-024 ARB_MODE 1: on a grant to index w, ptr <= (w+1) mod NUM_INPUTS; wrap from NUM_INPUTS-1 to 0; with no grant ptr holds.
REQ-025 Modulo SHALL be correct for non-power-of-two NUM_INPUTS (ptr never exceeds NUM_INPUTS-1).
REQ-026 A channel dropping in_valid while not granted SHALL have no effect on state.
REQ-027 X on in_data of ungranted channels SHALL not propagate to out.

Reset
REQ-028 While reset_n is 0: out_valid = 0, out = 0, out_sel = 0, ptr = 0, in_ready = all zero, independent of clk.
REQ-029 Assertion mid-transfer SHALL discard the held word; first grant after release follows ptr = 0.
REQ-030 Release SHALL take effect on the first rising clk edge after reset_n goes high.

Verification
REQ-031 Defaults, reset, then in_valid=4'b0001, in_data ch0=64 -> next cycle out=64, out_valid=1, out_sel=0.
REQ-032 ARB_MODE=1, all four valid, out_ready held 1, ch i data = 100+i -> out sequence 100,101,102,103,100 on consecutive cycles, out_sel 0,1,2,3,0.
REQ-033 ARB_MODE=0, all valid, out_ready=1 -> out stays 100, out_sel=0 every cycle; in_ready=4'b0001.
REQ-034 Backpressure: out_valid=1, out=45, out_ready=0 for 3 cycles with ch2 valid -> out stays 45, in_ready=0; on out_ready=1 ch2 loads next edge.
REQ-035 NUM_INPUTS=3, ARB_MODE=1, only ch2 valid repeatedly -> ptr wraps 0 to 0 via 2; then ch0 and ch1 valid -> ch0 wins.
REQ-036 reset_n pulsed low mid-stream with out_valid=1 -> out_valid=0, out=0 immediately, no clock required; next grant from ptr=0.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready arbiter feeding a single-entry registered
// output stage. Arbitration is either fixed priority (lowest index wins) or
// round robin with a rotating priority pointer.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready. Once out_valid is
// raised, out and out_sel stay stable until out_ready takes the word.
// in_ready is combinational and is at most one-hot.
module arb_mux #(
  parameter int BUS_BITS   = 64,
  parameter int NUM_INPUTS = 4,
  parameter int ARB_MODE   = 1,
  parameter int SEL_BITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_INPUTS*BUS_BITS-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  output logic [NUM_INPUTS-1:0]          in_ready,
  output logic [BUS_BITS-1:0]            out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SEL_BITS-1:0]            out_sel,
  output logic [SEL_BITS-1:0]            dbg_ptr_o
);

  // One extra bit so that pointer + offset never overflows before the
  // modulo reduction (both operands are below NUM_INPUTS).
  localparam int IDX_BITS = SEL_BITS + 1;
  localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(NUM_INPUTS - 1);

  logic [BUS_BITS-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_BITS-1:0] out_sel_q, out_sel_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;

  logic                can_load;
  logic [SEL_BITS-1:0] base;
  logic [IDX_BITS-1:0] cand;
  logic                grant_found;
  logic [SEL_BITS-1:0] grant_idx;
  logic                grant;

  // Priority search starting at the base index, wrapping modulo NUM_INPUTS.
  always_comb begin
    can_load    = !out_valid_q || out_ready;
    base        = (ARB_MODE == 1) ? ptr_q : '0;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, base} + IDX_BITS'(k);
      if (cand >= IDX_BITS'(NUM_INPUTS)) begin
        cand = cand - IDX_BITS'(NUM_INPUTS);
      end
      if (!grant_found && in_valid[cand[SEL_BITS-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SEL_BITS-1:0];
      end
    end
    // reset_n gates the grant so in_ready is quiet while reset is held.
    grant = reset_n && can_load && grant_found;
  end

  // Handshake response and next-state values for the output stage and pointer.
  always_comb begin
    in_ready    = '0;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (grant) begin
      in_ready[grant_idx] = 1'b1;
      // Only the granted slice is read, so junk on idle channels stays out.
      out_d       = in_data[grant_idx*BUS_BITS +: BUS_BITS];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (ARB_MODE == 1) begin
        ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_BITS'(1);
      end
    end else if (out_ready) begin
      // Pop without refill: data and select keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // Output register stage; reset discards any held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
    end
  end

  // Round-robin priority pointer; stays at zero in fixed-priority mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign dbg_ptr_o = ptr_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: three instances (4-ch round robin, 4-ch fixed priority,
// 3-ch round robin) stepped together against a cycle-level reference model.
module tb_arb_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // instance 0: defaults (64-bit, 4 inputs, round robin)
  logic [255:0] d0;
  logic [3:0]   v0, rdy0;
  logic [63:0]  o0;
  logic         ov0, r0;
  logic [1:0]   sel0, ptr0;
  // instance 1: fixed priority
  logic [255:0] d1;
  logic [3:0]   v1, rdy1;
  logic [63:0]  o1;
  logic         ov1, r1;
  logic [1:0]   sel1, ptr1;
  // instance 2: 3 inputs, 16-bit, round robin
  logic [47:0]  d2;
  logic [2:0]   v2, rdy2;
  logic [15:0]  o2;
  logic         ov2, r2;
  logic [1:0]   sel2, ptr2;

  arb_mux #(.BUS_BITS(64), .NUM_INPUTS(4), .ARB_MODE(1)) u_rr4 (
    .clk(clk), .reset_n(reset_n), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
    .out(o0), .out_valid(ov0), .out_ready(r0), .out_sel(sel0), .dbg_ptr_o(ptr0));
  arb_mux #(.BUS_BITS(64), .NUM_INPUTS(4), .ARB_MODE(0)) u_fp4 (
    .clk(clk), .reset_n(reset_n), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .out(o1), .out_valid(ov1), .out_ready(r1), .out_sel(sel1), .dbg_ptr_o(ptr1));
  arb_mux #(.BUS_BITS(16), .NUM_INPUTS(3), .ARB_MODE(1)) u_rr3 (
    .clk(clk), .reset_n(reset_n), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
    .out(o2), .out_valid(ov2), .out_ready(r2), .out_sel(sel2), .dbg_ptr_o(ptr2));

  // ---------------- reference model state ----------------
  int          m_n[3]    = '{4, 4, 3};
  int          m_mode[3] = '{1, 0, 1};
  int          m_ptr[3];
  bit          m_vld[3];
  logic [63:0] m_out[3];
  int          m_sel[3];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- per-instance accessors ----------------
  function automatic int in_v(input int inst);
    case (inst)
      0: return int'(v0);
      1: return int'(v1);
      default: return int'(v2);
    endcase
  endfunction

  function automatic logic [63:0] in_d(input int inst, input int ch);
    case (inst)
      0: return d0[ch*64 +: 64];
      1: return d1[ch*64 +: 64];
      default: return {48'b0, d2[ch*16 +: 16]};
    endcase
  endfunction

  function automatic bit in_r(input int inst);
    case (inst)
      0: return r0;
      1: return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic [63:0] dut_rdy(input int inst);
    case (inst)
      0: return {60'b0, rdy0};
      1: return {60'b0, rdy1};
      default: return {61'b0, rdy2};
    endcase
  endfunction

  function automatic logic [63:0] dut_out(input int inst);
    case (inst)
      0: return o0;
      1: return o1;
      default: return {48'b0, o2};
    endcase
  endfunction

  function automatic logic [63:0] dut_ov(input int inst);
    case (inst)
      0: return {63'b0, ov0};
      1: return {63'b0, ov1};
      default: return {63'b0, ov2};
    endcase
  endfunction

  function automatic logic [63:0] dut_sel(input int inst);
    case (inst)
      0: return {62'b0, sel0};
      1: return {62'b0, sel1};
      default: return {62'b0, sel2};
    endcase
  endfunction

  function automatic logic [63:0] dut_ptr(input int inst);
    case (inst)
      0: return {62'b0, ptr0};
      1: return {62'b0, ptr1};
      default: return {62'b0, ptr2};
    endcase
  endfunction

  // First requesting channel in the circular order start, start+1, ...
  function automatic int pick(input int v, input int n, input int start);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (start + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    v0 = '0; v1 = '0; v2 = '0;
    d0 = '0; d1 = '0; d2 = '0;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ptr[i] = 0; m_vld[i] = 1'b0; m_out[i] = '0; m_sel[i] = 0;
    end
  endtask

  // One clock: check in_ready against the model, clock, check outputs.
  task automatic step();
    int          w[3];
    bit          rd[3];
    logic [63:0] wd[3];
    logic [63:0] exp_rdy;
    bit          can_load;
    #1;
    for (int i = 0; i < 3; i++) begin
      can_load = !m_vld[i] || in_r(i);
      w[i]  = can_load ? pick(in_v(i), m_n[i], (m_mode[i] == 1) ? m_ptr[i] : 0) : -1;
      rd[i] = in_r(i);
      wd[i] = (w[i] >= 0) ? in_d(i, w[i]) : '0;
      exp_rdy = '0;
      if (w[i] >= 0) exp_rdy[w[i]] = 1'b1;
      check($sformatf("in_ready%0d", i), dut_rdy(i), exp_rdy);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (w[i] >= 0) begin
        m_out[i] = wd[i];
        m_sel[i] = w[i];
        m_vld[i] = 1'b1;
        if (m_mode[i] == 1) m_ptr[i] = (w[i] + 1) % m_n[i];
      end else if (rd[i]) begin
        m_vld[i] = 1'b0;
      end
      check($sformatf("out_valid%0d", i), dut_ov(i), 64'(m_vld[i]));
      check($sformatf("out%0d", i), dut_out(i), m_out[i]);
      check($sformatf("out_sel%0d", i), dut_sel(i), 64'(m_sel[i]));
      check($sformatf("ptr%0d", i), dut_ptr(i), 64'(m_ptr[i]));
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid%0d", i), dut_ov(i), 64'd0);
      check($sformatf("rst_out%0d", i), dut_out(i), 64'd0);
      check($sformatf("rst_sel%0d", i), dut_sel(i), 64'd0);
      check($sformatf("rst_ptr%0d", i), dut_ptr(i), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    apply_reset();

    // single request on channel 0
    v0 = 4'b0001; d0[63:0] = 64'd64; r0 = 1'b1;
    step();
    check("t31_out", o0, 64'd64);
    check("t31_valid", {63'b0, ov0}, 64'd1);
    check("t31_sel", {62'b0, sel0}, 64'd0);

    // all four requesting, no backpressure: rotation vs fixed priority
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      d0[i*64 +: 64] = 64'(100 + i);
      d1[i*64 +: 64] = 64'(100 + i);
    end
    v0 = 4'hf; v1 = 4'hf;
    for (int i = 0; i < 5; i++) exp_q.push_back(64'(100 + (i % 4)));
    for (int k = 0; k < 5; k++) begin
      step();
      check("t32_out", o0, exp_q.pop_front());
      check("t32_sel", {62'b0, sel0}, 64'(k % 4));
      check("t33_out", o1, 64'd100);
      check("t33_sel", {62'b0, sel1}, 64'd0);
      check("t33_rdy", {60'b0, rdy1}, 64'd1);
    end

    // backpressure holds the word and blocks new grants
    apply_reset();
    v0 = 4'b0100; d0[128 +: 64] = 64'd45; r0 = 1'b0;
    step();
    check("t34_load", o0, 64'd45);
    d0[128 +: 64] = 64'd77;
    repeat (3) begin
      step();
      check("t34_hold", o0, 64'd45);
      check("t34_rdy", {60'b0, rdy0}, 64'd0);
    end
    r0 = 1'b1;
    #1;
    check("t34_rdy_go", {60'b0, rdy0}, 64'h4);
    step();
    check("t34_next", o0, 64'd77);
    check("t34_sel", {62'b0, sel0}, 64'd2);

    // 3-input pointer wraps from the last channel back to 0
    apply_reset();
    v2 = 3'b100; d2[32 +: 16] = 16'h0222;
    step();
    check("t35_sel", {62'b0, sel2}, 64'd2);
    check("t35_wrap", {62'b0, ptr2}, 64'd0);
    step();
    check("t35_wrap2", {62'b0, ptr2}, 64'd0);
    v2 = 3'b011; d2[0 +: 16] = 16'h00a0; d2[16 +: 16] = 16'h00b1;
    step();
    check("t35_ch0_wins", {62'b0, sel2}, 64'd0);
    check("t35_ch0_out", {48'b0, o2}, 64'h00a0);

    // asynchronous reset mid-stream, then grant restarts at pointer 0
    apply_reset();
    for (int i = 0; i < 4; i++) d0[i*64 +: 64] = 64'(100 + i);
    v0 = 4'hf;
    step();
    step();
    check("t36_pre_ptr", {62'b0, ptr0}, 64'd2);
    reset_n = 1'b0;
    #1;
    check("t36_valid", {63'b0, ov0}, 64'd0);
    check("t36_out", o0, 64'd0);
    check("t36_sel", {62'b0, sel0}, 64'd0);
    check("t36_ptr", {62'b0, ptr0}, 64'd0);
    check("t36_rdy", {60'b0, rdy0}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    step();
    check("t36_regrant", {62'b0, sel0}, 64'd0);
    check("t36_regrant_out", o0, 64'd100);

    // randomized traffic, idle channels carry unknown data
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      v0 = 4'($urandom_range(0, 15));
      v1 = 4'($urandom_range(0, 15));
      v2 = 3'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 1) != 0);
      for (int ch = 0; ch < 4; ch++) begin
        d0[ch*64 +: 64] = v0[ch] ? {$urandom, $urandom} : 64'bx;
        d1[ch*64 +: 64] = v1[ch] ? {$urandom, $urandom} : 64'bx;
      end
      for (int ch = 0; ch < 3; ch++) begin
        d2[ch*16 +: 16] = v2[ch] ? 16'($urandom) : 16'bx;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
